// File: rtl/vc_fifo_arbiter.sv
// ============================================================================
// Module  : vc_fifo_arbiter
// Brief   : Round-robin burst scheduler draining NUM_VC FWFT VC FIFOs into one
//           shared output FIFO with pause / idle / error status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_fifo_arbiter #(
    parameter int NUM_VC     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [NUM_VC-1:0]              vc_empty_i,
    input  logic [NUM_VC*DATA_WIDTH-1:0]   vc_data_i,
    output logic [NUM_VC-1:0]              vc_pop_o,
    input  logic                           out_full_i,
    input  logic                           out_almost_full_i,
    output logic                           out_push_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic [$clog2(NUM_VC)-1:0]      out_vc_o,
    output logic                           pause_o,
    output logic                           idle_o,
    output logic                           error_full_o
);

    localparam int VW = $clog2(NUM_VC);
    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARB   = 3'd1,
        S_XFER  = 3'd2,
        S_PAUSE = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [VW-1:0]           g_q, g_d;
    logic [BW-1:0]           bc_q, bc_d;
    logic                    out_push_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [VW-1:0]           out_vc_q;

    logic [NUM_VC-1:0]       w_pop;
    logic [VW-1:0]           w_next_g;
    logic                    w_any;
    logic [VW-1:0]           w_idx;
    logic [DATA_WIDTH-1:0]   w_head;

    assign w_any  = ~&vc_empty_i;
    assign w_head = vc_data_i[g_q*DATA_WIDTH +: DATA_WIDTH];

    // Search g+1, g+2, ... with wrap; offset NUM_VC aliases back to g, so g is tried last.
    always_comb begin
        w_next_g = g_q;
        w_idx    = g_q;
        for (int k = NUM_VC; k >= 1; k--) begin
            w_idx = g_q + VW'(k);
            if (!vc_empty_i[w_idx]) begin
                w_next_g = w_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        bc_d    = bc_q;
        w_pop   = '0;
        case (state_q)
            S_INIT: begin
                if (start_i) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (out_almost_full_i) begin
                    state_d = S_PAUSE;
                end else if (w_any) begin
                    g_d     = w_next_g;
                    bc_d    = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (out_push_q && out_full_i) begin
                    state_d = S_ERROR;
                end else if (out_almost_full_i) begin
                    state_d = S_PAUSE;
                end else if (vc_empty_i[g_q]) begin
                    state_d = S_ARB;
                end else begin
                    w_pop[g_q] = 1'b1;
                    if (bc_q == BW'(BURST - 1)) begin
                        bc_d    = '0;
                        state_d = S_ARB;
                    end else begin
                        bc_d = bc_q + BW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (!out_almost_full_i) begin
                    state_d = S_ARB;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            g_q        <= VW'(NUM_VC - 1);
            bc_q       <= '0;
            out_push_q <= 1'b0;
            out_data_q <= '0;
            out_vc_q   <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            bc_q       <= bc_d;
            out_push_q <= |w_pop;
            out_data_q <= w_head;
            out_vc_q   <= g_q;
        end
    end

    // Reset wins even over the combinational pop so no word leaves a FIFO during rst.
    assign vc_pop_o     = rst ? '0 : w_pop;
    assign out_push_o   = out_push_q;
    assign out_data_o   = out_data_q;
    assign out_vc_o     = out_vc_q;
    assign pause_o      = (state_q == S_PAUSE);
    assign idle_o       = (state_q == S_ARB) && !w_any;
    assign error_full_o = (state_q == S_ERROR);

endmodule

`default_nettype wire
